pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage RV32I pipeline. Generates stall and flush controls for the F/D/E stages, including the IF/ID register enable. It covers:
- load-use and branch hazards;
- a fixed-latency instruction-memory wait-state generator;
- data-memory back-pressure;
- a post-reset pipeline purge.

It also keeps a saturating stall-cycle performance counter.

## Interface
- IMEM_WAIT, 0, extra wait cycles per instruction fetch (0..15)
- INIT_CYCLES, 3, cycles of forced flush after reset (1..15)
- CNT_W, 32, width of stall counter
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- MemReadE  in  1  instruction in E is a load
- RdE  in  5  destination register of E
- Rs1D, Rs2D  in  5 each  source registers of D
- PCSrcE  in  1  taken branch/jump resolved in E
- dmem_busy  in  1  data memory not ready; freeze pipeline
- StallF  out  1  hold PC
- StallD  out  1  hold IF/ID (IF/ID EN = ~StallD)
- StallE  out  1  hold ID/EX
- FlushD  out  1  load NOP into IF/ID
- FlushE  out  1  load NOP into ID/EX
- fetch_valid  out  1  InstrF valid this cycle
- stall_cnt  out  CNT_W  cycles with StallF=1, saturating

## Operation
- States: INIT, RUN, IWAIT.
- INIT:
  - init counter loaded with INIT_CYCLES-1 on reset; decrements each cycle.
  - Outputs: FlushD=FlushE=1, StallF=1, fetch_valid=0.
  - Go to RUN when the counter reaches 0 (i.e. after INIT_CYCLES cycles), or to IWAIT if IMEM_WAIT>0.
- Wait counter wc:
  - Loaded with IMEM_WAIT on every new fetch address: PC advances (StallF=0) or redirect (PCSrcE).
  - Decrements in IWAIT; fetch_valid=1 only when wc==0.
- IWAIT (wc>0):
  - StallF=1; FlushD=1 unless StallD (bubble into D).
  - At wc==1, next state is RUN.
- RUN: fetch_valid=1. If StallF=0 and IMEM_WAIT>0, go to IWAIT for the next address.
- Load-use hazard: lu = MemReadE & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D). Response: StallF=1, StallD=1, FlushE=1.
- Branch (PCSrcE=1):
  - FlushD=1, FlushE=1, StallF=0 so the PC loads the target; StallD=0.
  - Overrides lu.
  - In IWAIT, wc reloads with IMEM_WAIT and the state stays or returns to IWAIT (goes to RUN if IMEM_WAIT=0).
- dmem_busy=1, highest priority in RUN/IWAIT:
  - StallF=StallD=StallE=1; FlushD=FlushE=0.
  - wc and state frozen; a PCSrcE arriving during dmem_busy is ignored (E is held, so it is re-presented).
- Priority order: INIT > dmem_busy > PCSrcE > lu > IWAIT.
- stall_cnt: increments when StallF=1 (including INIT); holds at all-ones.
- All outputs except stall_cnt are combinational from state/counters/inputs. State, wc, init counter and stall_cnt are registered.

## Timing
- Reset (async, rst=1): state=INIT, init counter=INIT_CYCLES-1, wc=IMEM_WAIT, stall_cnt=0. Outputs while in reset: StallF=1, StallD=0, StallE=0, FlushD=1, FlushE=1, fetch_valid=0.
- Reset deassertion mid-operation: any cycle; INIT sequence restarts in full.
- First fetch_valid=1:
  - IMEM_WAIT=0: INIT_CYCLES cycles after the first rising edge with rst=0.
  - IMEM_WAIT=N: INIT_CYCLES+N cycles after that edge.
- Steady state, IMEM_WAIT=N: one instruction per N+1 cycles.
- Load-use: exactly one bubble; lu clears when the load leaves E.
- Branch: flush takes effect the same cycle PCSrcE is seen; the target fetch starts the next cycle.

## Test plan
- Reset, INIT_CYCLES=3, IMEM_WAIT=0: rst released -> FlushD=FlushE=StallF=1 for 3 cycles, then fetch_valid=1, StallF=0; stall_cnt=3.
- Load-use: MemReadE=1, RdE=5, Rs2D=5 for one cycle -> StallF=StallD=FlushE=1 that cycle only; RdE=0 with Rs1D=0 -> no stall.
- Branch with lu: PCSrcE=1 and lu=1 together -> FlushD=FlushE=1, StallF=StallD=0.
- IMEM_WAIT=2, straight-line code: fetch_valid pattern 1,0,0,1,0,0; FlushD=1 on the 0 cycles.
- IMEM_WAIT=2, PCSrcE at wc=1 -> wc reloads to 2; next fetch_valid 3 cycles later.
- dmem_busy for 4 cycles during IWAIT (wc=1) -> all stalls=1, no flush, wc stays 1; stall_cnt +4; then wait resumes. stall_cnt saturation with CNT_W=4: holds at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: stall/flush
// generation, imem wait states, dmem back-pressure, post-reset purge, stall counter.
module pipeline_hazard_ctrl #(
  parameter int unsigned IMEM_WAIT   = 0,
  parameter int unsigned INIT_CYCLES = 3,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemReadE,
  input  logic [4:0]       RdE,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic             PCSrcE,
  input  logic             dmem_busy,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             fetch_valid,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned   WC_W     = 4;
  localparam logic [WC_W-1:0] WAIT_LD  = WC_W'(IMEM_WAIT);
  localparam logic [WC_W-1:0] INIT_LD  = WC_W'(INIT_CYCLES - 1);
  localparam bit            HAS_WAIT = (IMEM_WAIT != 0);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_IWAIT = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WC_W-1:0]  r_wc, w_wc_nxt;
  logic [WC_W-1:0]  r_init_cnt, w_init_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_lu;

  assign w_lu = MemReadE & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));

  // State, wait counter and purge counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_INIT;
      r_wc       <= WAIT_LD;
      r_init_cnt <= INIT_LD;
    end else begin
      r_state    <= w_state_nxt;
      r_wc       <= w_wc_nxt;
      r_init_cnt <= w_init_nxt;
    end
  end

  // Next state and control outputs; priority INIT > dmem_busy > PCSrcE > lu > IWAIT
  always_comb begin
    w_state_nxt = r_state;
    w_wc_nxt    = r_wc;
    w_init_nxt  = r_init_cnt;
    StallF      = 1'b0;
    StallD      = 1'b0;
    StallE      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    fetch_valid = (r_state != S_INIT) && (r_wc == '0);
    case (r_state)
      S_INIT: begin
        StallF = 1'b1;
        FlushD = 1'b1;
        FlushE = 1'b1;
        if (r_init_cnt == '0) begin
          w_state_nxt = HAS_WAIT ? S_IWAIT : S_RUN;
          w_wc_nxt    = WAIT_LD;
        end else begin
          w_init_nxt = r_init_cnt - WC_W'(1);
        end
      end
      default: begin
        if (dmem_busy) begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
        end else if (PCSrcE) begin
          FlushD      = 1'b1;
          FlushE      = 1'b1;
          w_wc_nxt    = WAIT_LD;
          w_state_nxt = HAS_WAIT ? S_IWAIT : S_RUN;
        end else begin
          if (w_lu) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
          end
          if (r_state == S_IWAIT) begin
            // Fetch still outstanding: bubble into D unless D is being held
            StallF   = 1'b1;
            FlushD   = ~w_lu;
            w_wc_nxt = r_wc - WC_W'(1);
            if (r_wc == WC_W'(1)) w_state_nxt = S_RUN;
          end else if (!w_lu && HAS_WAIT) begin
            w_state_nxt = S_IWAIT;
            w_wc_nxt    = WAIT_LD;
          end
        end
      end
    endcase
  end

  // Saturating count of cycles with the PC held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (StallF && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (no wait states / 2 wait states)
// checked every cycle against a latency-countdown model plus literal expectations.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned INIT_C = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       MemReadE = 1'b0;
  logic [4:0] RdE = '0, Rs1D = '0, Rs2D = '0;
  logic       PCSrcE = 1'b0;
  logic       dmem_busy = 1'b0;

  logic        sf [2];
  logic        sd [2];
  logic        se [2];
  logic        fd [2];
  logic        fe [2];
  logic        fv [2];
  logic [3:0]  cnt0;
  logic [31:0] cnt2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.IMEM_WAIT(0), .INIT_CYCLES(INIT_C), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .MemReadE(MemReadE), .RdE(RdE), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .PCSrcE(PCSrcE), .dmem_busy(dmem_busy), .StallF(sf[0]), .StallD(sd[0]), .StallE(se[0]),
    .FlushD(fd[0]), .FlushE(fe[0]), .fetch_valid(fv[0]), .stall_cnt(cnt0));

  pipeline_hazard_ctrl #(.IMEM_WAIT(2), .INIT_CYCLES(INIT_C), .CNT_W(32)) dut2 (
    .clk(clk), .rst(rst), .MemReadE(MemReadE), .RdE(RdE), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .PCSrcE(PCSrcE), .dmem_busy(dmem_busy), .StallF(sf[1]), .StallD(sd[1]), .StallE(se[1]),
    .FlushD(fd[1]), .FlushE(fe[1]), .fetch_valid(fv[1]), .stall_cnt(cnt2));

  // Model: remaining purge cycles and remaining fetch latency for the current address
  int     m_wait_cfg [2] = '{0, 2};
  longint m_cnt_max  [2] = '{15, 64'hFFFF_FFFF};
  int     m_init [2];
  int     m_wait [2];
  longint m_cnt  [2];

  typedef struct packed {
    logic sf, sd, se, fd, fe, fv;
  } exp_t;

  function automatic bit lu_now();
    return MemReadE && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
  endfunction

  function automatic exp_t model_out(int i);
    exp_t e;
    e = '0;
    if (m_init[i] > 0) begin
      e.sf = 1; e.fd = 1; e.fe = 1;
      return e;
    end
    e.fv = (m_wait[i] == 0);
    if (dmem_busy) begin
      e.sf = 1; e.sd = 1; e.se = 1;
    end else if (PCSrcE) begin
      e.fd = 1; e.fe = 1;
    end else begin
      if (lu_now()) begin e.sf = 1; e.sd = 1; e.fe = 1; end
      if (m_wait[i] > 0) begin e.sf = 1; e.fd = !lu_now(); end
    end
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_init[i] = INIT_C;
        m_wait[i] = m_wait_cfg[i];
        m_cnt[i]  = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        exp_t e;
        e = model_out(i);
        if (e.sf && m_cnt[i] < m_cnt_max[i]) m_cnt[i]++;
        if (m_init[i] > 0)          m_init[i]--;
        else if (dmem_busy)         ;
        else if (PCSrcE)            m_wait[i] = m_wait_cfg[i];
        else if (m_wait[i] > 0)     m_wait[i]--;
        else if (!lu_now())         m_wait[i] = m_wait_cfg[i];
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      e = model_out(i);
      chk($sformatf("m%0d.StallF", i), 32'(sf[i]), 32'(e.sf));
      chk($sformatf("m%0d.StallD", i), 32'(sd[i]), 32'(e.sd));
      chk($sformatf("m%0d.StallE", i), 32'(se[i]), 32'(e.se));
      chk($sformatf("m%0d.FlushD", i), 32'(fd[i]), 32'(e.fd));
      chk($sformatf("m%0d.FlushE", i), 32'(fe[i]), 32'(e.fe));
      chk($sformatf("m%0d.fetch_valid", i), 32'(fv[i]), 32'(e.fv));
    end
    chk("m0.stall_cnt", 32'(cnt0), 32'(m_cnt[0]));
    chk("m1.stall_cnt", cnt2, 32'(m_cnt[1]));
  end

  task automatic clear_in();
    MemReadE = 0; RdE = 0; Rs1D = 0; Rs2D = 0; PCSrcE = 0; dmem_busy = 0;
  endtask

  task automatic do_reset();
    rst = 1; clear_in();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    clear_in();
    @(negedge clk);
    chk("rst.StallF", 32'(sf[0]), 1);
    chk("rst.StallD", 32'(sd[0]), 0);
    chk("rst.FlushD", 32'(fd[0]), 1);
    chk("rst.FlushE", 32'(fe[0]), 1);
    chk("rst.fetch_valid", 32'(fv[0]), 0);
    chk("rst.stall_cnt", 32'(cnt0), 0);

    // Purge, steady fetch, load-use, branch overriding load-use
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      clear_in();
      case (k)
        12: begin MemReadE = 1; RdE = 5; Rs2D = 5; end
        14: begin MemReadE = 1; RdE = 0; Rs1D = 0; end
        15: begin MemReadE = 1; RdE = 7; Rs1D = 7; PCSrcE = 1; end
        default: ;
      endcase
      @(negedge clk);
      if (k <= 3) begin
        chk("init.StallF", 32'(sf[0]), 1);
        chk("init.FlushD", 32'(fd[0]), 1);
        chk("init.FlushE", 32'(fe[0]), 1);
        chk("init.fetch_valid", 32'(fv[0]), 0);
      end
      if (k == 4) begin
        chk("first.fetch_valid", 32'(fv[0]), 1);
        chk("first.StallF", 32'(sf[0]), 0);
        chk("first.stall_cnt", 32'(cnt0), 3);
      end
      if (k >= 6 && k <= 11) begin
        chk("iw.fetch_valid", 32'(fv[1]), ((k - 6) % 3 == 0) ? 1 : 0);
        chk("iw.FlushD", 32'(fd[1]), ((k - 6) % 3 == 0) ? 0 : 1);
      end
      if (k == 12) begin
        chk("lu.StallF", 32'(sf[0]), 1);
        chk("lu.StallD", 32'(sd[0]), 1);
        chk("lu.FlushE", 32'(fe[0]), 1);
      end
      if (k == 13) chk("lu_end.StallF", 32'(sf[0]), 0);
      if (k == 14) chk("x0.StallF", 32'(sf[0]), 0);
      if (k == 15) begin
        chk("br_lu.FlushD", 32'(fd[0]), 1);
        chk("br_lu.FlushE", 32'(fe[0]), 1);
        chk("br_lu.StallF", 32'(sf[0]), 0);
        chk("br_lu.StallD", 32'(sd[0]), 0);
      end
      @(posedge clk); #1;
    end

    // Redirect while the 2-wait fetch has one cycle left
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      clear_in();
      PCSrcE = (k == 5);
      @(negedge clk);
      if (k == 5) chk("iw_br.StallF", 32'(sf[1]), 0);
      if (k == 6 || k == 7) chk("iw_br.fv_lo", 32'(fv[1]), 0);
      if (k == 8) chk("iw_br.fv_hi", 32'(fv[1]), 1);
      @(posedge clk); #1;
    end

    // Data-memory back-pressure for 4 cycles at wc=1
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      clear_in();
      dmem_busy = (k >= 5 && k <= 8);
      @(negedge clk);
      if (k >= 5 && k <= 8) begin
        chk("busy.StallE", 32'(se[1]), 1);
        chk("busy.FlushD", 32'(fd[1]), 0);
        chk("busy.fetch_valid", 32'(fv[1]), 0);
      end
      if (k == 9) begin
        chk("busy_end.stall_cnt", cnt2, 8);
        chk("busy_end.fetch_valid", 32'(fv[1]), 0);
      end
      if (k == 10) chk("busy_resume.fetch_valid", 32'(fv[1]), 1);
      @(posedge clk); #1;
    end

    // Randomized traffic with occasional mid-run resets
    for (int k = 0; k < 3000; k++) begin
      rst       = ($urandom_range(0, 199) == 0);
      MemReadE  = $urandom_range(0, 1) == 1;
      RdE       = 5'($urandom_range(0, 3));
      Rs1D      = 5'($urandom_range(0, 3));
      Rs2D      = 5'($urandom_range(0, 3));
      PCSrcE    = ($urandom_range(0, 7) == 0);
      dmem_busy = ($urandom_range(0, 7) == 0);
      @(posedge clk); #1;
    end

    // Saturate the 4-bit counter with a held load-use hazard
    rst = 0; clear_in();
    MemReadE = 1; RdE = 1; Rs1D = 1;
    repeat (20) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("sat.stall_cnt", 32'(cnt0), 15);
    clear_in();
    @(posedge clk); #1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
